// File: rtl/hwpe_ctrl_serial_mult.sv
// Digit-serial signed/unsigned multiplier with negate and accumulate modes.
// Operands are latched at accept; A is consumed MULT_BITS per cycle, LSB digit first.
module hwpe_ctrl_serial_mult #(
   parameter int AW        = 8,
   parameter int BW        = 8,
   parameter int MULT_BITS = 4,
   parameter int PW        = AW + BW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          start_i,
   input  logic [AW-1:0] a_i,
   input  logic [BW-1:0] b_i,
   input  logic          a_signed_i,
   input  logic          b_signed_i,
   input  logic          invert_i,
   input  logic          acc_i,
   output logic          ready_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [PW-1:0] prod_o
);

   localparam int N      = (AW + MULT_BITS - 1) / MULT_BITS;
   localparam int AW_PAD = N * MULT_BITS;
   localparam int CW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state_r;
   logic [1:0]           state_s;
   logic [CW-1:0]        cnt_r;
   logic [AW_PAD-1:0]    a_r;
   logic [AW_PAD-1:0]    a_pad_s;
   logic [PW-1:0]        b_r;
   logic [PW-1:0]        b_ext_s;
   logic [PW-1:0]        acc_r;
   logic [PW-1:0]        digit_ext_s;
   logic [PW-1:0]        term_s;
   logic [PW-1:0]        sum_s;
   logic [MULT_BITS-1:0] digit_s;
   logic                 a_signed_r;
   logic                 invert_r;
   logic                 ready_r;
   logic                 valid_r;
   logic                 accept_s;
   logic                 last_s;
   logic                 top_neg_s;

   // Signed casts of {sign, value} give sign- or zero-extension selected by the mode bit.
   assign a_pad_s = AW_PAD'($signed({a_signed_i & a_i[AW-1], a_i}));
   assign b_ext_s = PW'($signed({b_signed_i & b_i[BW-1], b_i}));

   // Datapath: current digit times the pre-shifted B, added or subtracted.
   always_comb begin
      digit_s     = a_r[MULT_BITS-1:0];
      last_s      = (cnt_r == LAST);
      top_neg_s   = last_s & a_signed_r & digit_s[MULT_BITS-1];
      digit_ext_s = PW'($signed({top_neg_s, digit_s}));
      term_s      = digit_ext_s * b_r;
      if (invert_r) begin
         sum_s = acc_r - term_s;
      end else begin
         sum_s = acc_r + term_s;
      end
   end

   assign accept_s = start_i & (state_r == IDLE);

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = BUSY;
            end
         end
         DONE: begin
            if (ready_i) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Control registers; handshake outputs are registered copies of the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else if (clear_i) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         valid_r <= (state_s == DONE);
      end
   end

   // Operand shifters, digit counter and accumulator.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_r        <= '0;
         b_r        <= '0;
         acc_r      <= '0;
         cnt_r      <= '0;
         a_signed_r <= 1'b0;
         invert_r   <= 1'b0;
      end else if (clear_i) begin
         a_r        <= '0;
         b_r        <= '0;
         acc_r      <= '0;
         cnt_r      <= '0;
         a_signed_r <= 1'b0;
         invert_r   <= 1'b0;
      end else if (accept_s) begin
         a_r        <= a_pad_s;
         b_r        <= b_ext_s;
         acc_r      <= acc_i ? acc_r : '0;
         cnt_r      <= '0;
         a_signed_r <= a_signed_i;
         invert_r   <= invert_i;
      end else if (state_r == BUSY) begin
         // Shifting B left each step applies the digit weight without a variable shifter.
         a_r   <= a_r >> MULT_BITS;
         b_r   <= b_r << MULT_BITS;
         acc_r <= sum_s;
         cnt_r <= last_s ? '0 : cnt_r + CW'(1);
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end

   assign ready_o = ready_r;
   assign valid_o = valid_r;
   assign prod_o  = acc_r;

endmodule
